// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback path.
package rf_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  typedef struct packed {
    logic [AW-1:0]   dest;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LD  = 1'b1
  } gnt_src_t;
endpackage

// File: rtl/wb_fifo.sv
// Writeback FIFO: DEPTH entries of {dest,data}, power-of-two depth.
// Also exposes every slot in age order (oldest first) with a valid bit,
// so the bypass search can scan the queue without knowing the pointers.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic                   push,
  input  wb_entry_t              push_ent,
  input  logic                   pop,
  output wb_entry_t              head_ent,
  output logic [CW-1:0]          count,
  output wb_entry_t [DEPTH-1:0]  ent_ord,
  output logic [DEPTH-1:0]       vld_ord
);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   head, tail;

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; payload needs no reset since validity comes from count.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_ent;
  end

  assign head_ent = mem[head];

  // Age-ordered view: slot k is the k-th oldest queued entry.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent_ord[k] = mem[head + PW'(k)];
      vld_ord[k] = (CW'(k) < count);
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset_l)
    push |-> (count != CW'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_l)
    pop |-> (count != '0));
  a_count_range:  assert property (@(posedge clk) disable iff (!reset_l)
    count <= CW'(DEPTH));

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-side controller: round-robin arbitration of ALU and
// load results into a writeback FIFO, a registered RF write stage, and a
// two-port bypass lookup over everything not yet committed to the RF.
module rf_writeback_ctrl
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = rf_pkg::XLEN,
  parameter int AW    = rf_pkg::AW,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset_l,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_dest,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_dest,
  input  logic [XLEN-1:0] ld_data,
  input  logic            rf_hold,
  output logic            rf_we,
  output logic [AW-1:0]   rf_dest,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [AW-1:0]   byp_addr1,
  input  logic [AW-1:0]   byp_addr2,
  output logic            byp_hit1,
  output logic            byp_hit2,
  output logic [XLEN-1:0] byp_data1,
  output logic [XLEN-1:0] byp_data2,
  output logic [CW-1:0]   count
);

  gnt_src_t              rr_q;
  logic                  full, contested;
  logic                  alu_acc, ld_acc, push, pop;
  wb_entry_t             push_ent, head_ent, out_q;
  wb_entry_t [DEPTH-1:0] ent_ord;
  logic [DEPTH-1:0]      vld_ord;

  // Readies look only at registered occupancy, never at this cycle's pop,
  // so rf_hold has no combinational path into them.
  assign full      = (count == CW'(DEPTH));
  assign contested = alu_valid & ld_valid;
  assign alu_ready = reset_l & ~full & ~(contested & (rr_q == GNT_LD));
  assign ld_ready  = reset_l & ~full & ~(contested & (rr_q == GNT_ALU));

  assign alu_acc  = alu_valid & alu_ready;
  assign ld_acc   = ld_valid  & ld_ready;
  assign push_ent = alu_acc ? '{dest: alu_dest, data: alu_data}
                            : '{dest: ld_dest,  data: ld_data};
  // r0 writes complete the handshake but are dropped here.
  assign push     = (alu_acc & (alu_dest != '0)) | (ld_acc & (ld_dest != '0));
  assign pop      = (count != '0) & ~rf_hold;

  // Round-robin pointer flips only when a contested cycle actually granted.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)               rr_q <= GNT_ALU;
    else if (contested && !full) rr_q <= (rr_q == GNT_ALU) ? GNT_LD : GNT_ALU;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_l  (reset_l),
    .push     (push),
    .push_ent (push_ent),
    .pop      (pop),
    .head_ent (head_ent),
    .count    (count),
    .ent_ord  (ent_ord),
    .vld_ord  (vld_ord)
  );

  // Output stage: head moves to the RF write port; holds value when idle.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      rf_we <= 1'b0;
      out_q <= '0;
    end else begin
      rf_we <= pop;
      if (pop) out_q <= head_ent;
    end
  end

  assign rf_dest  = out_q.dest;
  assign rf_wdata = out_q.data;

  // Scan oldest to youngest (output stage first) so the last match wins.
  function automatic logic [XLEN:0] byp_search(input logic [AW-1:0] a);
    logic            hit;
    logic [XLEN-1:0] d;
    hit = 1'b0;
    d   = '0;
    if (rf_we && out_q.dest == a) begin
      hit = 1'b1;
      d   = out_q.data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (vld_ord[k] && ent_ord[k].dest == a) begin
        hit = 1'b1;
        d   = ent_ord[k].data;
      end
    end
    if (a == '0) begin
      hit = 1'b0;
      d   = '0;
    end
    return {hit, d};
  endfunction

  // Bypass lookups for both read ports.
  always_comb begin
    {byp_hit1, byp_data1} = byp_search(byp_addr1);
    {byp_hit2, byp_data2} = byp_search(byp_addr2);
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed bench for rf_writeback_ctrl with hand-computed expectations.
module tb_rf_writeback_ctrl;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset_l;
  logic            alu_valid, alu_ready, ld_valid, ld_ready;
  logic [AW-1:0]   alu_dest, ld_dest, rf_dest, byp_addr1, byp_addr2;
  logic [XLEN-1:0] alu_data, ld_data, rf_wdata, byp_data1, byp_data2;
  logic            rf_hold, rf_we, byp_hit1, byp_hit2;
  logic [CW-1:0]   count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rf_writeback_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .reset_l(reset_l),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
    .rf_hold(rf_hold), .rf_we(rf_we), .rf_dest(rf_dest), .rf_wdata(rf_wdata),
    .byp_addr1(byp_addr1), .byp_addr2(byp_addr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2),
    .count(count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_l = 1'b0; rf_hold = 1'b0;
    alu_valid = 1'b1; alu_dest = 5'd1; alu_data = 32'h11;
    ld_valid = 1'b0;  ld_dest = '0;    ld_data = '0;
    byp_addr1 = '0;   byp_addr2 = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_we",     rf_we,     0);
    check("rst_dest",   rf_dest,   0);
    check("rst_wdata",  rf_wdata,  0);
    check("rst_count",  count,     0);
    check("rst_alu_rdy", alu_ready, 0);
    check("rst_ld_rdy", ld_ready,  0);
    reset_l = 1'b1; alu_dest = 5'd0;
    #1;
    check("rel_alu_rdy", alu_ready, 1);
    alu_valid = 1'b0;

    // single write, latency and bypass from queue then output stage
    step();
    alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    check("sw_rdy", alu_ready, 1);
    step();
    alu_valid = 1'b0; byp_addr1 = 5'd5;
    #1;
    check("sw_cnt1",   count,     1);
    check("sw_we0",    rf_we,     0);
    check("sw_byp_q",  byp_hit1,  1);
    check("sw_bdat_q", byp_data1, 32'hDEADBEEF);
    step();
    check("sw_we1",    rf_we,     1);
    check("sw_dest",   rf_dest,   5);
    check("sw_wdata",  rf_wdata,  32'hDEADBEEF);
    check("sw_cnt0",   count,     0);
    check("sw_byp_o",  byp_hit1,  1);
    step();
    check("sw_we_off", rf_we,     0);
    check("sw_hold",   rf_dest,   5);
    check("sw_byp_gone", byp_hit1, 0);

    // contention: ALU, LD, ALU, LD
    alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'h1;
    ld_valid  = 1'b1; ld_dest  = 5'd4; ld_data  = 32'h2;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("ct_alu_rdy%0d", i), alu_ready, (i % 2 == 0));
      check($sformatf("ct_ld_rdy%0d", i),  ld_ready,  (i % 2 == 1));
      if (i >= 2) begin
        check($sformatf("ct_we%0d", i),   rf_we,   1);
        check($sformatf("ct_dest%0d", i), rf_dest, (i % 2 == 0) ? 3 : 4);
      end
      step();
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    #1;
    check("ct_dest_e4",  rf_dest,  3);
    check("ct_data_e4",  rf_wdata, 1);
    step();
    check("ct_dest_e5",  rf_dest,  4);
    check("ct_data_e5",  rf_wdata, 2);
    check("ct_cnt",      count,    0);
    step();
    check("ct_we_off",   rf_we,    0);

    // backpressure to full, then drain in order
    rf_hold = 1'b1;
    for (int d = 1; d <= 4; d++) begin
      alu_valid = 1'b1; alu_dest = AW'(d); alu_data = 32'h100 + 32'(d);
      #1;
      check($sformatf("fl_rdy%0d", d), alu_ready, 1);
      step();
    end
    alu_valid = 1'b0; byp_addr1 = 5'd3;
    #1;
    check("fl_cnt4",    count,     4);
    check("fl_alu_rdy", alu_ready, 0);
    check("fl_ld_rdy",  ld_ready,  0);
    check("fl_we",      rf_we,     0);
    check("fl_byp",     byp_data1, 32'h103);
    rf_hold = 1'b0;
    step();
    check("dr_we1",    rf_we,     1);
    check("dr_dest1",  rf_dest,   1);
    check("dr_cnt3",   count,     3);
    check("dr_rdy",    alu_ready, 1);
    for (int d = 2; d <= 4; d++) begin
      step();
      check($sformatf("dr_we%0d", d),   rf_we,    1);
      check($sformatf("dr_dest%0d", d), rf_dest,  d);
      check($sformatf("dr_data%0d", d), rf_wdata, 32'h100 + 32'(d));
    end
    step();
    check("dr_we_off", rf_we, 0);
    check("dr_cnt0",   count, 0);

    // bypass youngest, r0 drop, same-cycle invisibility
    rf_hold = 1'b1;
    alu_valid = 1'b1; alu_dest = 5'd7; alu_data = 32'hA;
    #1;
    step();
    alu_data = 32'hB;
    #1;
    step();
    alu_valid = 1'b0; byp_addr1 = 5'd7;
    #1;
    check("by_hit",   byp_hit1,  1);
    check("by_young", byp_data1, 32'hB);
    check("by_cnt",   count,     2);
    ld_valid = 1'b1; ld_dest = 5'd0; ld_data = 32'h55;
    #1;
    check("r0_rdy", ld_ready, 1);
    step();
    ld_valid = 1'b0; byp_addr2 = 5'd0;
    #1;
    check("r0_cnt",  count,     2);
    check("r0_hit",  byp_hit2,  0);
    check("r0_data", byp_data2, 0);
    alu_valid = 1'b1; alu_dest = 5'd9; alu_data = 32'hC; byp_addr2 = 5'd9;
    #1;
    check("by_same_cyc", byp_hit2, 0);
    step();
    alu_valid = 1'b0;
    #1;
    check("by_new_hit",  byp_hit2,  1);
    check("by_new_data", byp_data2, 32'hC);
    check("by_cnt3",     count,     3);

    // reset mid-operation
    reset_l = 1'b0;
    #1;
    check("mr_cnt",  count,     0);
    check("mr_we",   rf_we,     0);
    check("mr_rdy",  alu_ready, 0);
    check("mr_byp",  byp_hit1,  0);
    reset_l = 1'b1; rf_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mr_stale%0d", i), rf_we, 0);
    end
    alu_valid = 1'b1; alu_dest = 5'd2; alu_data = 32'h77;
    #1;
    step();
    alu_valid = 1'b0;
    step();
    check("pr_we",   rf_we,    1);
    check("pr_dest", rf_dest,  2);
    check("pr_data", rf_wdata, 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rf_writeback_ctrl.md
Name: rf_writeback_ctrl

Overview:
Write-side controller for the 32x32 register file (2 read ports, 1 write port, r0 hardwired zero).
- Accepts results from two producers, ALU and load unit, via valid/ready.
- Arbitrates between them round-robin and buffers results in a small FIFO.
- Drives the RF write port one entry per cycle.
- Gives read-side logic a bypass lookup so it sees results that are not yet written.

Parameters:
DEPTH, 4, writeback FIFO entries; power of two, minimum 2
XLEN, 32, data width
AW, 5, register address width (32 registers)

Ports:
clk  in  1  clock, all state on posedge
reset_l  in  1  reset, asynchronous, active-low
alu_valid  in  1  ALU result valid
alu_ready  out  1  ALU result accepted when valid&ready at posedge
alu_dest  in  AW  ALU destination register
alu_data  in  XLEN  ALU result
ld_valid  in  1  load result valid
ld_ready  out  1  load result accepted when valid&ready at posedge
ld_dest  in  AW  load destination register
ld_data  in  XLEN  load result
rf_hold  in  1  RF write port borrowed (debug/scan); blocks pops
rf_we  out  1  RF write enable (registered)
rf_dest  out  AW  RF write address (registered)
rf_wdata  out  XLEN  RF write data (registered)
byp_addr1  in  AW  bypass lookup address, port 1
byp_addr2  in  AW  bypass lookup address, port 2
byp_hit1  out  1  pending write to byp_addr1 exists
byp_hit2  out  1  pending write to byp_addr2 exists
byp_data1  out  XLEN  youngest pending value for byp_addr1
byp_data2  out  XLEN  youngest pending value for byp_addr2
count  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the output stage

Behaviour:
- Reset (async, reset_l low): FIFO empty; count=0; rf_we=0; rf_dest=0; rf_wdata=0; round-robin pointer favours ALU. Reset mid-operation discards all queued and output-stage entries. Readies are 0 while reset_l is low.
- Readies: alu_ready = ld_ready = (count != DEPTH), further gated by arbitration.
  - Only one producer is granted per cycle. The loser sees ready=0.
  - Ready never depends on the same-cycle pop, so there is no combinational path from rf_hold to the readies.
- Arbitration: if both are valid, grant the side that did not win the last contested cycle. The pointer updates only on contested cycles. A single valid requester is always granted when not full.
- Enqueue: an accepted {dest,data} is written to the FIFO tail.
  - dest==0: the handshake completes but no entry is written and count is unchanged, because r0 is read-only zero.
- Pop (each posedge): if count!=0 and rf_hold=0, the head moves into rf_dest/rf_wdata, rf_we<=1, and count decrements. Otherwise rf_we<=0, and rf_dest/rf_wdata hold their values.
- Latency: accept at edge N into an empty FIFO with rf_hold=0 gives rf_we=1 during cycle N+1. The RF commits at edge N+2. Sustained throughput is 1 write/cycle.
- Simultaneous enqueue and pop: count is unchanged, and a full FIFO stays full for that cycle.
- Pointers: head and tail are AW-independent $clog2(DEPTH)-bit counters that wrap modulo DEPTH. Full/empty is decided from count.
- Bypass (combinational):
  - Search, youngest first: FIFO entries tail-1 down to head, then the output stage if rf_we=1.
  - byp_hitN=1 with the youngest matching data.
  - byp_addrN==0 gives hit=0, data=0.
  - No match gives hit=0, data=0.
  - An entry accepted this cycle (not yet registered) is not visible.
- Output ordering: RF writes occur in acceptance order. A later write to the same dest always overwrites an earlier one.
- Assertions:
  - No enqueue when full.
  - No pop when empty.
  - count <= DEPTH.

Decomposition:
- Package rf_pkg holds:
  - XLEN, AW, NREG=32 constants.
  - A typedef wb_entry_t {logic [AW-1:0] dest; logic [XLEN-1:0] data;}.
  - An enum for grant source {GNT_ALU, GNT_LD}.
- Sub-module wb_fifo is natural: parameterised DEPTH storage of wb_entry_t with push/pop/count, plus a flat read-out of all entries and valid bits for the bypass search.
- Arbitration, output stage and bypass live in rf_writeback_ctrl.

Test Plan:
- Reset: hold reset_l=0 with alu_valid=1 -> rf_we=0, rf_dest=0, rf_wdata=0, count=0, readies 0. Release reset -> alu_ready=1.
- Single write: ALU dest=5 data=0xDEADBEEF accepted at edge N -> rf_we=1, rf_dest=5, rf_wdata=0xDEADBEEF in cycle N+1; count returns to 0.
- Contention: alu (dest 3, 0x1) and ld (dest 4, 0x2) both valid for 4 cycles -> grants alternate ALU, LD, ALU, LD; RF writes appear in the same order.
- Backpressure/full: rf_hold=1 with DEPTH=4 ALU results to dests 1-4 -> count=4 and alu_ready=0. Release rf_hold -> 4 consecutive rf_we cycles in order; ready reasserts the cycle after the first pop.
- Bypass youngest/r0: queue dest 7 =0xA then dest 7 =0xB with rf_hold=1 -> byp_addr1=7 gives hit=1, data=0xB. ld dest=0 accepted -> count unchanged; byp_addr2=0 gives hit=0.
- Reset mid-operation: 3 entries queued, pulse reset_l low -> count=0 and rf_we=0 immediately; no stale writes after reset is released.
